// File: rtl/bias_fetch_engine.sv
// ---------------------------------------------------------------------------
// bias_fetch_engine
//
// Purpose:
//   ICB read engine that fills one bias tile for the bias loader. On an
//   accepted start it latches the bias base address, the output-channel count
//   m and the tile column, works out how many lanes of the tile are real
//   channels (n_valid) and fetches exactly those words with single-beat ICB
//   reads. Lanes past n_valid stay zero. A one-cycle done pulse marks the
//   vector as complete.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           launch pulse, honoured only while idle
//   bias_base       byte base address of the bias array
//   m               total number of output channels
//   tile_col        tile column index
//   busy            high while a fetch is in progress (ISSUE/DRAIN/DONE)
//   done            one-cycle pulse when bias_data is complete
//   err             sticky error flag for the current fetch
//   icb_cmd_*       ICB command channel (read, single beat, word size)
//   icb_rsp_*       ICB response channel (always ready)
//   bias_data       SIZE-lane bias vector
// ---------------------------------------------------------------------------
module bias_fetch_engine #(
  parameter int SIZE            = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int REG_WIDTH       = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [REG_WIDTH-1:0]  bias_base,
  input  logic [REG_WIDTH-1:0]  m,
  input  logic [REG_WIDTH-1:0]  tile_col,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  icb_cmd_valid,
  input  logic                  icb_cmd_ready,
  output logic [REG_WIDTH-1:0]  icb_cmd_addr,
  output logic                  icb_cmd_read,
  output logic [2:0]            icb_cmd_len,
  output logic [1:0]            icb_cmd_size,
  input  logic                  icb_rsp_valid,
  input  logic [DATA_WIDTH-1:0] icb_rsp_rdata,
  input  logic                  icb_rsp_err,
  output logic                  icb_rsp_ready,
  output logic [DATA_WIDTH-1:0] bias_data [SIZE]
);

  localparam int CW = $clog2(SIZE + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [REG_WIDTH-1:0]    base_q, base_d;
  logic [REG_WIDTH-1:0]    first_q, first_d;
  logic [CW-1:0]           n_valid_q, n_valid_d;
  logic [CW-1:0]           issued_q, issued_d;
  logic [CW-1:0]           rsp_cnt_q, rsp_cnt_d;
  logic [OW-1:0]           outst_q, outst_d;
  logic                    cmd_valid_q, cmd_valid_d;
  logic [REG_WIDTH-1:0]    cmd_addr_q, cmd_addr_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   bias_q [SIZE];
  logic [DATA_WIDTH-1:0]   bias_d [SIZE];

  logic [2*REG_WIDTH-1:0]  first_wide;
  logic [2*REG_WIDTH-1:0]  m_wide;
  logic [REG_WIDTH-1:0]    remain;
  logic [CW-1:0]           n_valid_new;
  logic                    hs_cmd;
  logic                    hs_rsp;

  // Byte address of lane idx: word index first+idx scaled to bytes, wrapping
  // naturally in REG_WIDTH.
  function automatic logic [REG_WIDTH-1:0] lane_addr(
    input logic [REG_WIDTH-1:0] base,
    input logic [REG_WIDTH-1:0] first,
    input logic [CW-1:0]        idx
  );
    return base + ((first + REG_WIDTH'(idx)) << 2);
  endfunction

  // Lane count of the tile being requested. The column offset is formed at
  // double width so an overflowing tile_col*SIZE reads as "past m" and gives
  // an empty tile instead of aliasing onto a low column.
  always_comb begin
    first_wide  = {{REG_WIDTH{1'b0}}, tile_col} * (2*REG_WIDTH)'(SIZE);
    m_wide      = {{REG_WIDTH{1'b0}}, m};
    remain      = '0;
    n_valid_new = '0;
    if (first_wide < m_wide) begin
      remain = m - first_wide[REG_WIDTH-1:0];
      if (remain >= REG_WIDTH'(SIZE)) begin
        n_valid_new = CW'(SIZE);
      end else begin
        n_valid_new = CW'(remain);
      end
    end
  end

  // Next-state logic. Responses are only consumed into the tile while a
  // fetch is active; anything arriving in IDLE/DONE is dropped. The command
  // register is reloaded only when empty or just accepted, so valid and
  // address hold steady across a stalled handshake.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    first_d     = first_q;
    n_valid_d   = n_valid_q;
    issued_d    = issued_q;
    rsp_cnt_d   = rsp_cnt_q;
    outst_d     = outst_q;
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    err_d       = err_q;
    bias_d      = bias_q;

    hs_cmd = cmd_valid_q & icb_cmd_ready;
    hs_rsp = icb_rsp_valid & ((state_q == S_ISSUE) | (state_q == S_DRAIN))
             & (rsp_cnt_q < n_valid_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d    = bias_base;
          first_d   = first_wide[REG_WIDTH-1:0];
          n_valid_d = n_valid_new;
          issued_d  = '0;
          rsp_cnt_d = '0;
          outst_d   = '0;
          err_d     = 1'b0;
          for (int l = 0; l < SIZE; l++) begin
            bias_d[l] = '0;
          end
          if (n_valid_new == '0) begin
            state_d     = S_DONE;
            cmd_valid_d = 1'b0;
          end else begin
            state_d     = S_ISSUE;
            cmd_valid_d = 1'b1;
            cmd_addr_d  = lane_addr(bias_base, first_wide[REG_WIDTH-1:0], '0);
          end
        end
      end

      S_ISSUE, S_DRAIN: begin
        if (hs_cmd) begin
          issued_d = issued_q + 1'b1;
        end

        case ({hs_cmd, hs_rsp})
          2'b10:   outst_d = outst_q + 1'b1;
          2'b01:   outst_d = (outst_q != '0) ? outst_q - 1'b1 : outst_q;
          default: outst_d = outst_q;
        endcase

        // Responses come back in order, so the running count is the lane.
        if (hs_rsp) begin
          for (int l = 0; l < SIZE; l++) begin
            if (CW'(l) == rsp_cnt_q) begin
              bias_d[l] = icb_rsp_err ? '0 : icb_rsp_rdata;
            end
          end
          if (icb_rsp_err) begin
            err_d = 1'b1;
          end
          rsp_cnt_d = rsp_cnt_q + 1'b1;
        end

        if (state_q == S_ISSUE) begin
          if (!cmd_valid_q || hs_cmd) begin
            if ((issued_d < n_valid_q) && (outst_d < OW'(MAX_OUTSTANDING))) begin
              cmd_valid_d = 1'b1;
              cmd_addr_d  = lane_addr(base_q, first_q, issued_d);
            end else begin
              cmd_valid_d = 1'b0;
            end
          end
        end else begin
          cmd_valid_d = 1'b0;
        end

        if (rsp_cnt_d == n_valid_q) begin
          state_d     = S_DONE;
          cmd_valid_d = 1'b0;
        end else if ((state_q == S_ISSUE) && (issued_d == n_valid_q)) begin
          state_d = S_DRAIN;
        end
      end

      S_DONE: begin
        state_d     = S_IDLE;
        cmd_valid_d = 1'b0;
      end

      default: begin
        state_d     = S_IDLE;
        cmd_valid_d = 1'b0;
      end
    endcase
  end

  // All state, including the command and vector outputs, lives here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      first_q     <= '0;
      n_valid_q   <= '0;
      issued_q    <= '0;
      rsp_cnt_q   <= '0;
      outst_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      err_q       <= 1'b0;
      for (int l = 0; l < SIZE; l++) begin
        bias_q[l] <= '0;
      end
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      first_q     <= first_d;
      n_valid_q   <= n_valid_d;
      issued_q    <= issued_d;
      rsp_cnt_q   <= rsp_cnt_d;
      outst_q     <= outst_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      err_q       <= err_d;
      for (int l = 0; l < SIZE; l++) begin
        bias_q[l] <= bias_d[l];
      end
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign err           = err_q;
  assign icb_cmd_valid = cmd_valid_q;
  assign icb_cmd_addr  = cmd_addr_q;
  assign icb_cmd_read  = 1'b1;
  assign icb_cmd_len   = 3'd0;
  assign icb_cmd_size  = 2'b10;
  assign icb_rsp_ready = 1'b1;
  assign bias_data     = bias_q;

endmodule

// File: tb/tb_bias_fetch_engine.sv
// ---------------------------------------------------------------------------
// tb_bias_fetch_engine
//
// Randomised bench for bias_fetch_engine. A reference model computes the
// expected command addresses and final bias vector for each launch straight
// from the tile arithmetic; a monitor compares the DUT's command stream and
// done-time vector against those expectations. An ICB slave model returns
// rdata = addr with configurable command stalls, response delay and an
// optional error on one chosen address.
// ---------------------------------------------------------------------------
module tb_bias_fetch_engine;

  localparam int SIZE  = 16;
  localparam int DW    = 32;
  localparam int RW    = 32;
  localparam int MAXO  = 4;

  typedef struct packed {
    logic [SIZE-1:0][DW-1:0] lanes;
    logic                    err;
    logic [4:0]              nv;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [RW-1:0] bias_base;
  logic [RW-1:0] m;
  logic [RW-1:0] tile_col;
  logic          busy;
  logic          done;
  logic          err;
  logic          icb_cmd_valid;
  logic          icb_cmd_ready;
  logic [RW-1:0] icb_cmd_addr;
  logic          icb_cmd_read;
  logic [2:0]    icb_cmd_len;
  logic [1:0]    icb_cmd_size;
  logic          icb_rsp_valid;
  logic [DW-1:0] icb_rsp_rdata;
  logic          icb_rsp_err;
  logic          icb_rsp_ready;
  logic [DW-1:0] bias_data [SIZE];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  exp_t          exp_done_q[$];
  logic [RW-1:0] exp_addr_q[$];

  // slave configuration, owned by the main sequence
  int            rsp_delay    = 0;
  int            stall_cycles = 0;
  bit            ready_rand   = 1'b0;
  bit            err_en       = 1'b0;
  logic [RW-1:0] err_addr     = '0;

  // slave state
  logic [RW-1:0] pend_addr[$];
  int            pend_due[$];

  // monitor state
  int cmd_count    = 0;
  int done_count   = 0;
  int tb_out       = 0;
  int last_rsp_cyc = 0;
  int start_cyc    = 0;

  bias_fetch_engine #(
    .SIZE(SIZE), .DATA_WIDTH(DW), .REG_WIDTH(RW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .bias_base(bias_base), .m(m), .tile_col(tile_col),
    .busy(busy), .done(done), .err(err),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_len(icb_cmd_len), .icb_cmd_size(icb_cmd_size),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_rdata(icb_rsp_rdata),
    .icb_rsp_err(icb_rsp_err), .icb_rsp_ready(icb_rsp_ready),
    .bias_data(bias_data)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Lane i of tile tc covers channel tc*SIZE+i; only channels below m exist.
  function automatic logic [RW-1:0] chan_addr(input logic [RW-1:0] base, input longint unsigned chan);
    logic [63:0] full;
    full = {32'd0, base} + chan * 64'd4;
    return full[RW-1:0];
  endfunction

  function automatic exp_t refModel(input logic [RW-1:0] base, input logic [RW-1:0] mm,
                                    input logic [RW-1:0] tc);
    exp_t            e;
    longint unsigned first;
    longint unsigned avail;
    logic [RW-1:0]   a;
    e     = '0;
    first = {32'd0, tc} * 64'd16;
    avail = (first < {32'd0, mm}) ? ({32'd0, mm} - first) : 64'd0;
    e.nv  = (avail > 64'd16) ? 5'd16 : 5'(avail);
    for (int i = 0; i < int'(e.nv); i++) begin
      a = chan_addr(base, first + longint'(i));
      if (err_en && (a == err_addr)) begin
        e.lanes[i] = '0;
        e.err      = 1'b1;
      end else begin
        e.lanes[i] = a;
      end
    end
    return e;
  endfunction

  // ICB slave: handshakes are sampled at the negative edge, drives change
  // just after the positive edge.
  initial begin
    int stall_cnt;
    bit cmd_hs;
    bit rsp_hs;
    stall_cnt     = 0;
    icb_cmd_ready = 1'b0;
    icb_rsp_valid = 1'b0;
    icb_rsp_rdata = '0;
    icb_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      cmd_hs = icb_cmd_valid && icb_cmd_ready;
      rsp_hs = icb_rsp_valid && icb_rsp_ready;
      if (rsp_hs && pend_addr.size() > 0) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (cmd_hs) begin
        pend_addr.push_back(icb_cmd_addr);
        pend_due.push_back(cyc + 1 + rsp_delay);
        stall_cnt = 0;
      end else if (icb_cmd_valid) begin
        stall_cnt++;
      end
      @(posedge clk);
      #1;
      icb_cmd_ready = ready_rand ? 1'($urandom_range(0, 1)) : (stall_cnt >= stall_cycles);
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        icb_rsp_valid = 1'b1;
        if (err_en && pend_addr[0] == err_addr) begin
          icb_rsp_err   = 1'b1;
          icb_rsp_rdata = $urandom | 32'h1;
        end else begin
          icb_rsp_err   = 1'b0;
          icb_rsp_rdata = pend_addr[0];
        end
      end else begin
        icb_rsp_valid = 1'b0;
        icb_rsp_err   = 1'b0;
        icb_rsp_rdata = $urandom;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit            start_pending;
    bit            prev_stall;
    logic [RW-1:0] prev_addr;
    exp_t          e;
    start_pending = 1'b0;
    prev_stall    = 1'b0;
    prev_addr     = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tb_out        = 0;
        prev_stall    = 1'b0;
        start_pending = 1'b0;
      end else begin
        if (start_pending) begin
          checkOutput("busy after start", 32'(busy), 32'd1);
          checkOutput("err cleared on start", 32'(err), 32'd0);
          start_pending = 1'b0;
        end
        if (start && !busy) begin
          start_pending = 1'b1;
          start_cyc     = cyc;
        end

        if (prev_stall) begin
          checkOutput("cmd_valid held while stalled", 32'(icb_cmd_valid), 32'd1);
          checkOutput("cmd_addr held while stalled", icb_cmd_addr, prev_addr);
        end
        prev_stall = icb_cmd_valid && !icb_cmd_ready;
        prev_addr  = icb_cmd_addr;

        if (tb_out >= MAXO) begin
          checkOutput("cmd_valid low at limit", 32'(icb_cmd_valid), 32'd0);
        end

        if (icb_cmd_valid && icb_cmd_ready) begin
          checkOutput("cmd expected", 32'(exp_addr_q.size() > 0), 32'd1);
          if (exp_addr_q.size() > 0) begin
            checkOutput("cmd addr", icb_cmd_addr, exp_addr_q.pop_front());
          end
          checkOutput("cmd attrs", {26'd0, icb_cmd_read, icb_cmd_len, icb_cmd_size},
                      {26'd0, 1'b1, 3'd0, 2'b10});
          tb_out++;
          checkOutput("outstanding bound", 32'(tb_out <= MAXO), 32'd1);
          cmd_count++;
        end

        if (icb_rsp_valid && busy && !done) begin
          if (tb_out > 0) tb_out--;
          last_rsp_cyc = cyc;
        end

        if (done) begin
          checkOutput("done expected", 32'(exp_done_q.size() > 0), 32'd1);
          if (exp_done_q.size() > 0) begin
            e = exp_done_q.pop_front();
            for (int l = 0; l < SIZE; l++) begin
              checkOutput($sformatf("bias lane %0d", l), bias_data[l], e.lanes[l]);
            end
            checkOutput("err at done", 32'(err), 32'(e.err));
            if (e.nv == 5'd0) begin
              checkOutput("start->done latency", 32'(cyc - start_cyc), 32'd1);
            end else begin
              checkOutput("last rsp->done latency", 32'(cyc - last_rsp_cyc), 32'd1);
            end
            checkOutput("all cmds issued", 32'(exp_addr_q.size()), 32'd0);
          end
          done_count++;
        end
      end
    end
  end

  // Pushes expectations and pulses start; returns one cycle after acceptance.
  task automatic issueStart(input logic [RW-1:0] b, input logic [RW-1:0] mm,
                            input logic [RW-1:0] tc, output int nv);
    exp_t            e;
    longint unsigned first;
    e     = refModel(b, mm, tc);
    nv    = int'(e.nv);
    first = {32'd0, tc} * 64'd16;
    for (int i = 0; i < nv; i++) begin
      exp_addr_q.push_back(chan_addr(b, first + longint'(i)));
    end
    exp_done_q.push_back(e);
    start     = 1'b1;
    bias_base = b;
    m         = mm;
    tile_col  = tc;
    @(posedge clk);
    #1;
    start     = 1'b0;
    bias_base = $urandom;
    m         = $urandom;
    tile_col  = $urandom;
  endtask

  task automatic applyStimulus(input logic [RW-1:0] b, input logic [RW-1:0] mm,
                               input logic [RW-1:0] tc, input bit poke_busy);
    int target;
    int nv;
    target = done_count + 1;
    issueStart(b, mm, tc, nv);
    if (poke_busy && nv >= 4) begin
      start     = 1'b1;
      bias_base = $urandom;
      m         = 32'd1000;
      tile_col  = 32'd0;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    for (int k = 0; k < 3000 && done_count < target; k++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("done within budget", 32'(done_count), 32'(target));
    if (done_count < target) begin
      exp_addr_q.delete();
      exp_done_q.delete();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " done"}, 32'(done), 32'd0);
    checkOutput({tag, " err"}, 32'(err), 32'd0);
    checkOutput({tag, " cmd_valid"}, 32'(icb_cmd_valid), 32'd0);
    checkOutput({tag, " cmd_addr"}, icb_cmd_addr, 32'd0);
    for (int l = 0; l < SIZE; l++) begin
      checkOutput($sformatf("%s bias lane %0d", tag, l), bias_data[l], 32'd0);
    end
  endtask

  initial begin
    int            nv;
    int            base_cmds;
    logic [RW-1:0] rb;
    logic [RW-1:0] rm;
    logic [RW-1:0] rt;
    rst       = 1'b1;
    start     = 1'b0;
    bias_base = '0;
    m         = '0;
    tile_col  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] partial tile, zero-latency slave");
    applyStimulus(32'h1000, 32'd40, 32'd2, 1'b0);

    $display("[TB] empty tile");
    applyStimulus(32'h1000, 32'd40, 32'd3, 1'b0);

    $display("[TB] overflowing column offset");
    applyStimulus(32'h0, 32'hFFFF_FFFF, 32'h1000_0000, 1'b0);

    $display("[TB] full tile, 5-cycle command stalls");
    stall_cycles = 5;
    applyStimulus(32'h2000, 32'd64, 32'd0, 1'b0);
    stall_cycles = 0;

    $display("[TB] 10-cycle response delay, outstanding limit");
    rsp_delay = 10;
    applyStimulus(32'h3000, 32'd100, 32'd1, 1'b1);
    rsp_delay = 0;

    $display("[TB] error on third response");
    err_en   = 1'b1;
    err_addr = 32'h4008;
    applyStimulus(32'h4000, 32'd20, 32'd0, 1'b0);
    err_en = 1'b0;
    applyStimulus(32'h4000, 32'd20, 32'd1, 1'b0);

    $display("[TB] address wrap");
    applyStimulus(32'hFFFF_FFF0, 32'd50, 32'd0, 1'b0);

    $display("[TB] reset mid-fetch");
    base_cmds = cmd_count;
    issueStart(32'h5000, 32'd64, 32'd0, nv);
    for (int k = 0; k < 200 && cmd_count < base_cmds + 5; k++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("5 cmds before reset", 32'(cmd_count >= base_cmds + 5), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkResetState("mid-fetch reset");
    rst = 1'b0;
    exp_addr_q.delete();
    exp_done_q.delete();
    for (int k = 0; k < 100 && pend_addr.size() > 0; k++) begin
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idle responses discarded", bias_data[0], 32'd0);
    checkOutput("idle after reset", 32'(busy), 32'd0);
    applyStimulus(32'h5000, 32'd64, 32'd0, 1'b0);

    $display("[TB] randomised fetches");
    for (int t = 0; t < 10; t++) begin
      rb           = $urandom & 32'hFFFF_FFFC;
      rm           = 32'($urandom_range(0, 80));
      rt           = 32'($urandom_range(0, 5));
      rsp_delay    = $urandom_range(0, 6);
      ready_rand   = 1'($urandom_range(0, 1));
      stall_cycles = $urandom_range(0, 3);
      err_en       = 1'($urandom_range(0, 1));
      err_addr     = chan_addr(rb, {32'd0, rt} * 64'd16 + longint'($urandom_range(0, 15)));
      applyStimulus(rb, rm, rt, 1'($urandom_range(0, 1)));
    end
    ready_rand   = 1'b0;
    stall_cycles = 0;
    rsp_delay    = 0;
    err_en       = 1'b0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
